// File: rtl/demux_1to16_sync.sv
// Registered 1-to-16 demultiplexer.
// Routes din onto the lane chosen by sel and forces the other fifteen lanes to
// zero. Also produces a one-hot lane marker and a one-cycle valid strobe. All
// outputs are registered, so there is no combinational path from input to output.
module demux_1to16_sync #(
    parameter int DATA_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3:0]             sel,
    input  logic [DATA_W-1:0]      din,
    output logic [16*DATA_W-1:0]   dout,
    output logic                   valid,
    output logic [15:0]            lane_onehot
);

    logic [16*DATA_W-1:0] dout_q,  dout_d;
    logic [15:0]          onehot_q, onehot_d;
    logic                 valid_q,  valid_d;

    // Next-state: a capture rebuilds every lane, an idle cycle holds the lanes and drops valid.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves
        // one unassigned and no latch is inferred.
        dout_d   = dout_q;
        onehot_d = onehot_q;
        valid_d  = 1'b0;
        if (en) begin
            dout_d   = '0;
            onehot_d = '0;
            valid_d  = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if (sel == 4'(k)) begin
                    dout_d[k*DATA_W +: DATA_W] = din;
                    onehot_d[k]                = 1'b1;
                end
            end
        end
    end

    // State register: synchronous reset takes priority over any capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its pre-edge value and simulation order has no effect.
        if (rst) begin
            dout_q   <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign dout        = dout_q;
    assign lane_onehot = onehot_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_demux_1to16_sync.sv
// Testbench for demux_1to16_sync. Stimulus pushes the expected outputs into a
// queue, and a separate monitor pops them and compares them on the falling edge.
module tb_demux_1to16_sync;

    localparam int DW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b0;
    logic [3:0]        sel = '0;
    logic [DW-1:0]     din = '0;
    logic [16*DW-1:0]  dout;
    logic              valid;
    logic [15:0]       lane_onehot;

    demux_1to16_sync #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sel         (sel),
        .din         (din),
        .dout        (dout),
        .valid       (valid),
        .lane_onehot (lane_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16*DW-1:0] dout;
        logic             valid;
        logic [15:0]      onehot;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: per-lane data and the index of the marked lane (-1 = none).
    int  lane_val [16];
    int  marked_lane = -1;
    bit  ref_valid   = 1'b0;
    bit  armed       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply the operation rules to the reference state for one rising edge.
    task automatic model_edge(input bit r, input bit e, input int s, input int d);
        if (r) begin
            foreach (lane_val[k]) lane_val[k] = 0;
            marked_lane = -1;
            ref_valid   = 1'b0;
        end else if (e) begin
            foreach (lane_val[k]) lane_val[k] = 0;
            lane_val[s] = d;
            marked_lane = s;
            ref_valid   = 1'b1;
        end else begin
            ref_valid = 1'b0;
        end
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.dout   = '0;
        x.onehot = '0;
        for (int k = 0; k < 16; k++) begin
            x.dout[k*DW +: DW] = DW'(lane_val[k]);
        end
        if (marked_lane >= 0) x.onehot = 16'(2 ** marked_lane);
        x.valid = ref_valid;
        return x;
    endfunction

    // Drive one cycle of inputs, let the edge happen, then record what must appear.
    task automatic step(input bit r, input bit e, input int s, input int d);
        rst = r;
        en  = e;
        sel = 4'(s);
        din = DW'(d);
        @(posedge clk);
        if (r) armed = 1'b1;
        model_edge(r, e, s, d);
        if (armed) sb.push_back(model_out());
        #1;
    endtask

    // Monitor: the outputs are live every cycle once reset has been seen.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("dout",        32'(dout),        32'(x.dout));
            check("valid",       32'(valid),       32'(x.valid));
            check("lane_onehot", 32'(lane_onehot), 32'(x.onehot));
        end
    end

    initial begin
        foreach (lane_val[k]) lane_val[k] = 0;
        @(posedge clk);
        #1;

        // Reset held two cycles while a transfer is requested.
        step(1, 1, 5, 1);
        step(1, 1, 5, 1);

        // Basic routing to lane 1.
        step(0, 1, 1, 1);

        // Sweep every lane back to back.
        for (int s = 0; s < 16; s++) step(0, 1, s, 1);

        // Capture lane 7, then hold while the inputs toggle.
        step(0, 1, 7, 1);
        for (int i = 0; i < 3; i++) step(0, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

        // Zero data still marks the lane.
        step(0, 1, 3, 0);

        // Reset mid-stream, then a normal transfer on release.
        step(0, 1, 10, 1);
        step(1, 1, 2, 1);
        step(0, 1, 2, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0),
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, (1 << DW) - 1)));
        end

        en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
